// File: rtl/wb_pkg.sv
// Shared types and sizes for the writeback arbiter.
package wb_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = $clog2(NREG);

  // One pending writeback: destination register and its data.
  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Load-response queue: DEPTH-deep synchronous FIFO of wb_entry_t.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wb_entry_t        entry_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic [CNT_W-1:0] count_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointers and occupancy from this cycle's push/pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write.
  // NOTE: storage is deliberately not reset; count_q gates every read, so stale data is never used.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results with queued load responses onto the
// register-file write port and tracks in-flight loads for hazard detection.
// Optional same-cycle load bypass (empty queue, no ALU) via `define WB_LD_BYPASS_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter  int LQ_DEPTH = 2,
  localparam int CNT_W    = $clog2(LQ_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_wb_valid,
  input  logic [REG_IDX_W-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]      alu_wb_data,
  input  logic                 ld_issue_valid,
  input  logic [REG_IDX_W-1:0] ld_issue_rd,
  input  logic                 ld_rsp_valid,
  output logic                 ld_rsp_ready,
  input  logic [REG_IDX_W-1:0] ld_rsp_rd,
  input  logic [XLEN-1:0]      ld_rsp_data,
  input  logic [REG_IDX_W-1:0] chk_rs1,
  input  logic [REG_IDX_W-1:0] chk_rs2,
  input  logic [REG_IDX_W-1:0] chk_rd,
  output logic                 hazard,
  output logic                 RegWrite,
  output logic [REG_IDX_W-1:0] Rd,
  output logic [XLEN-1:0]      Write_data,
  output logic [NREG-1:0]      pending,
  output logic [CNT_W-1:0]     lq_count
);

  logic                 ld_acc, q_empty, bypass, push, pop;
  wb_entry_t            head;
  logic                 sel_valid;
  logic [REG_IDX_W-1:0] sel_rd;
  logic [XLEN-1:0]      sel_data;
  logic                 regwrite_q;
  logic [REG_IDX_W-1:0] rd_q;
  logic [XLEN-1:0]      data_q;
  logic [NREG-1:0]      pending_q, pending_d;

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign ld_rsp_ready = (lq_count != CNT_W'(LQ_DEPTH));
  assign ld_acc       = ld_rsp_valid && ld_rsp_ready;
  assign q_empty      = (lq_count == '0);

`ifdef WB_LD_BYPASS_EN
  assign bypass = ld_acc && !alu_wb_valid && q_empty;
`else
  assign bypass = 1'b0;
`endif

  assign push = ld_acc && !bypass;
  assign pop  = !alu_wb_valid && !q_empty;

  wb_load_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .entry_i ('{rd: ld_rsp_rd, data: ld_rsp_data}),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (lq_count)
  );

  // Writeback source select: ALU first, then queue head, then bypassed response.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (alu_wb_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_wb_rd;
      sel_data  = alu_wb_data;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_rd    = head.rd;
      sel_data  = head.data;
    end else if (bypass) begin
      sel_valid = 1'b1;
      sel_rd    = ld_rsp_rd;
      sel_data  = ld_rsp_data;
    end
  end

  // Scoreboard update: clear on load retirement, then set on issue so set wins.
  always_comb begin
    pending_d = pending_q;
    if (pop)    pending_d[head.rd]   = 1'b0;
    if (bypass) pending_d[ld_rsp_rd] = 1'b0;
    if (ld_issue_valid && ld_issue_rd != '0) pending_d[ld_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Register-file write port and scoreboard state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
      pending_q  <= '0;
    end else begin
      regwrite_q <= sel_valid && (sel_rd != '0);
      if (sel_valid) begin
        rd_q   <= sel_rd;
        data_q <= sel_data;
      end
      pending_q <= pending_d;
    end
  end

  assign RegWrite   = regwrite_q;
  assign Rd         = rd_q;
  assign Write_data = data_q;
  assign pending    = pending_q;
  assign hazard     = pending_q[chk_rs1] | pending_q[chk_rs2] | pending_q[chk_rd];

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter; latency expectations follow WB_LD_BYPASS_EN.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 alu_wb_valid = 1'b0;
  logic [REG_IDX_W-1:0] alu_wb_rd = '0;
  logic [XLEN-1:0]      alu_wb_data = '0;
  logic                 ld_issue_valid = 1'b0;
  logic [REG_IDX_W-1:0] ld_issue_rd = '0;
  logic                 ld_rsp_valid = 1'b0;
  logic                 ld_rsp_ready;
  logic [REG_IDX_W-1:0] ld_rsp_rd = '0;
  logic [XLEN-1:0]      ld_rsp_data = '0;
  logic [REG_IDX_W-1:0] chk_rs1 = '0, chk_rs2 = '0, chk_rd = '0;
  logic                 hazard;
  logic                 RegWrite;
  logic [REG_IDX_W-1:0] Rd;
  logic [XLEN-1:0]      Write_data;
  logic [NREG-1:0]      pending;
  logic [1:0]           lq_count;

  int n_vec = 0;
  int n_err = 0;

  wb_arbiter #(.LQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_ready(ld_rsp_ready),
    .ld_rsp_rd(ld_rsp_rd), .ld_rsp_data(ld_rsp_data),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .hazard(hazard),
    .RegWrite(RegWrite), .Rd(Rd), .Write_data(Write_data),
    .pending(pending), .lq_count(lq_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic [REG_IDX_W-1:0] rd, input logic [XLEN-1:0] d);
    alu_wb_valid = v; alu_wb_rd = rd; alu_wb_data = d;
  endtask

  task automatic rsp(input logic v, input logic [REG_IDX_W-1:0] rd, input logic [XLEN-1:0] d);
    ld_rsp_valid = v; ld_rsp_rd = rd; ld_rsp_data = d;
  endtask

  task automatic issue(input logic v, input logic [REG_IDX_W-1:0] rd);
    ld_issue_valid = v; ld_issue_rd = rd;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_regwrite", 64'(RegWrite), 64'd0);
    check("rst_rd", 64'(Rd), 64'd0);
    check("rst_wdata", 64'(Write_data), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_count", 64'(lq_count), 64'd0);
    rst = 1'b1;
    tick();
    check("rst_ready", 64'(ld_rsp_ready), 64'd1);

    // ALU only
    alu(1'b1, 5'd5, 32'h1234);
    tick();
    alu(1'b0, 5'd0, 32'h0);
    check("alu_regwrite", 64'(RegWrite), 64'd1);
    check("alu_rd", 64'(Rd), 64'd5);
    check("alu_wdata", 64'(Write_data), 64'h1234);
    check("alu_pending", 64'(pending), 64'd0);
    tick();
    check("idle_regwrite", 64'(RegWrite), 64'd0);
    check("idle_rd_hold", 64'(Rd), 64'd5);

    // Load round trip
    issue(1'b1, 5'd7);
    tick();
    issue(1'b0, 5'd0);
    check("ld7_pending", 64'(pending), 64'h80);
    chk_rs1 = 5'd7; #1;
    check("ld7_hazard", 64'(hazard), 64'd1);
    chk_rs1 = 5'd0; chk_rd = 5'd6; #1;
    check("ld7_nohazard", 64'(hazard), 64'd0);
    chk_rd = 5'd0;
    rsp(1'b1, 5'd7, 32'hDEAD);
    tick();
    rsp(1'b0, 5'd0, 32'h0);
`ifdef WB_LD_BYPASS_EN
    check("ld7_byp_regwrite", 64'(RegWrite), 64'd1);
    check("ld7_byp_count", 64'(lq_count), 64'd0);
`else
    check("ld7_q_regwrite", 64'(RegWrite), 64'd0);
    check("ld7_q_count", 64'(lq_count), 64'd1);
    tick();
    check("ld7_regwrite", 64'(RegWrite), 64'd1);
`endif
    check("ld7_rd", 64'(Rd), 64'd7);
    check("ld7_wdata", 64'(Write_data), 64'hDEAD);
    check("ld7_cleared", 64'(pending), 64'd0);
    check("ld7_count0", 64'(lq_count), 64'd0);

    // Priority and backpressure
    issue(1'b1, 5'd3); tick();
    issue(1'b1, 5'd4); tick();
    issue(1'b1, 5'd6); tick();
    issue(1'b0, 5'd0);
    check("prio_pending", 64'(pending), 64'h58);
    alu(1'b1, 5'd10, 32'h100); rsp(1'b1, 5'd3, 32'hA); tick();
    check("prio_count1", 64'(lq_count), 64'd1);
    alu(1'b1, 5'd11, 32'h101); rsp(1'b1, 5'd4, 32'hB); tick();
    check("prio_count2", 64'(lq_count), 64'd2);
    check("prio_ready0", 64'(ld_rsp_ready), 64'd0);
    check("prio_alu_rd", 64'(Rd), 64'd11);
    alu(1'b1, 5'd12, 32'h102); rsp(1'b1, 5'd6, 32'hC); tick();
    check("prio_held_count", 64'(lq_count), 64'd2);
    alu(1'b1, 5'd13, 32'h103); tick();
    check("prio_held_ready", 64'(ld_rsp_ready), 64'd0);
    check("prio_alu_last", 64'(Write_data), 64'h103);
    alu(1'b0, 5'd0, 32'h0); tick();
    check("prio_w3_rd", 64'(Rd), 64'd3);
    check("prio_w3_data", 64'(Write_data), 64'hA);
    check("prio_w3_pending", 64'(pending), 64'h50);
    check("prio_w3_count", 64'(lq_count), 64'd1);
    tick();
    rsp(1'b0, 5'd0, 32'h0);
    check("prio_w4_rd", 64'(Rd), 64'd4);
    check("prio_w4_data", 64'(Write_data), 64'hB);
    check("prio_pushpop_count", 64'(lq_count), 64'd1);
    tick();
    check("prio_w6_rd", 64'(Rd), 64'd6);
    check("prio_w6_data", 64'(Write_data), 64'hC);
    check("prio_drained", 64'(lq_count), 64'd0);
    check("prio_pending0", 64'(pending), 64'd0);

    // x0 handling
    alu(1'b1, 5'd0, 32'h55); tick();
    alu(1'b0, 5'd0, 32'h0);
    check("x0_alu_regwrite", 64'(RegWrite), 64'd0);
    rsp(1'b1, 5'd0, 32'h66); tick();
    rsp(1'b0, 5'd0, 32'h0);
    check("x0_ld_regwrite_a", 64'(RegWrite), 64'd0);
    tick();
    check("x0_ld_regwrite_b", 64'(RegWrite), 64'd0);
    check("x0_drained", 64'(lq_count), 64'd0);
    check("x0_pending", 64'(pending), 64'd0);

    // Same-cycle set/clear on rd=9
    issue(1'b1, 5'd9); tick();
    issue(1'b0, 5'd0);
    alu(1'b1, 5'd1, 32'h11); rsp(1'b1, 5'd9, 32'h99); tick();
    alu(1'b0, 5'd0, 32'h0); rsp(1'b0, 5'd0, 32'h0);
    check("sc_count", 64'(lq_count), 64'd1);
    issue(1'b1, 5'd9); tick();
    issue(1'b0, 5'd0);
    check("sc_write_rd", 64'(Rd), 64'd9);
    check("sc_pending_set", 64'(pending), 64'h200);

    // Retire rd=9, then build the mid-operation reset scenario
    rsp(1'b1, 5'd9, 32'h98); tick();
    rsp(1'b0, 5'd0, 32'h0); tick();
    check("pre_rst_pending0", 64'(pending), 64'd0);
    issue(1'b1, 5'd3); tick();
    issue(1'b1, 5'd4); tick();
    issue(1'b0, 5'd0);
    alu(1'b1, 5'd20, 32'h200); rsp(1'b1, 5'd3, 32'h3); tick();
    alu(1'b1, 5'd21, 32'h201); rsp(1'b1, 5'd4, 32'h4); tick();
    rsp(1'b0, 5'd0, 32'h0);
    check("pre_rst_count", 64'(lq_count), 64'd2);
    check("pre_rst_pending", 64'(pending), 64'h18);
    check("pre_rst_regwrite", 64'(RegWrite), 64'd1);
    #2 rst = 1'b0;
    alu(1'b0, 5'd0, 32'h0);
    #1;
    check("mid_rst_count", 64'(lq_count), 64'd0);
    check("mid_rst_pending", 64'(pending), 64'd0);
    check("mid_rst_regwrite", 64'(RegWrite), 64'd0);
    #2 rst = 1'b1;
    tick();
    check("post_rst_ready", 64'(ld_rsp_ready), 64'd1);
    check("post_rst_count", 64'(lq_count), 64'd0);
    check("post_rst_regwrite", 64'(RegWrite), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter sitting directly upstream of the register file; drives its RegWrite/Rd/Write_data write port.
- Merges single-cycle ALU results with variable-latency data-memory load responses, which are buffered in a small load queue.
- Keeps a pending-load scoreboard so decode can stall on RAW/WAW hazards against loads still in flight.

Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers; register index width is $clog2(NREG).
- LQ_DEPTH, 2, load-response queue entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- alu_wb_valid  in  1  ALU result present this cycle; cannot be back-pressured
- alu_wb_rd  in  5  ALU destination register
- alu_wb_data  in  XLEN  ALU result
- ld_issue_valid  in  1  load dispatched to memory this cycle
- ld_issue_rd  in  5  destination register of the dispatched load
- ld_rsp_valid  in  1  memory load response valid
- ld_rsp_ready  out  1  queue can accept a response
- ld_rsp_rd  in  5  destination register of the response
- ld_rsp_data  in  XLEN  load data
- chk_rs1, chk_rs2, chk_rd  in  5 each  decode-stage register indices to check
- hazard  out  1  any checked index is pending (combinational)
- RegWrite  out  1  register-file write enable (registered)
- Rd  out  5  register-file write index (registered)
- Write_data  out  XLEN  register-file write data (registered)
- pending  out  NREG  scoreboard bitmap
- lq_count  out  $clog2(LQ_DEPTH)+1  queue occupancy

Behaviour:
- Reset (rst=0, async):
  - RegWrite, Rd, Write_data, pending and lq_count all go to 0; queue is emptied.
  - Applies mid-operation as well: in-flight queue contents and pending bits are discarded.
  - ld_rsp_ready reads 1 in the first cycle after reset release.
- Load acceptance:
  - A handshake occurs when ld_rsp_valid && ld_rsp_ready at the clock edge; the response is pushed into the FIFO.
  - ld_rsp_ready = (lq_count != LQ_DEPTH). It is registered-occupancy based and does not depend on a same-cycle pop.
- Selection, each cycle:
  - alu_wb_valid=1: the ALU entry is selected and the queue is not popped.
  - Otherwise, queue non-empty: the head is popped and selected.
  - Otherwise: nothing is selected.
- Output register: at the next edge RegWrite <= (selection made && sel_rd != 0); Rd and Write_data take the selected values.
  - With no selection, RegWrite=0 and Rd/Write_data hold their previous values.
  - Write latency is 1 cycle from the selection cycle.
- x0 handling: a selected entry with rd=0 still pops and clears its pending bit, but RegWrite stays 0.
- Scoreboard:
  - ld_issue_valid && ld_issue_rd != 0 sets pending[ld_issue_rd].
  - A queue pop clears pending[popped rd].
  - Set and clear of the same index in the same cycle: set wins.
  - pending[0] is always 0.
- hazard = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd]; index 0 never hits.
- Queue full with a push and a pop in the same cycle is impossible, because ready is already low when full.
- Queue empty: there is no pop, and no bypass unless the optional feature is enabled.
- Simultaneous push and pop with a non-empty, non-full queue: occupancy is unchanged; FIFO order is preserved.
- ALU-every-cycle starvation: the queue fills and ld_rsp_ready deasserts until an ALU-free cycle. This is legal; the upstream memory holds the response.
- Illegal inputs (caller guarantees these never occur via hazard stall):
  - issuing a load to an already-pending rd;
  - an ALU write to a pending rd;
  - a response whose rd is not pending.

Optional Feature:
- Macro: WB_LD_BYPASS_EN.
- Defined: when the queue is empty and alu_wb_valid=0, an accepted load response skips the queue and is selected the same cycle.
  - Result: RegWrite is high at the next edge (1-cycle load writeback); its pending bit is cleared at that edge; lq_count stays 0.
- Undefined: every response enters the queue.
  - Earliest RegWrite is 2 cycles after acceptance.

Decomposition:
- Package wb_pkg: XLEN, NREG, REG_IDX_W, and a wb_entry_t struct {rd, data}.
- One natural sub-module: wb_load_fifo (LQ_DEPTH-deep synchronous FIFO of wb_entry_t with push/pop/count, async active-low reset).
- Scoreboard and arbiter logic stay in the top module.

Test Plan:
- ALU only: alu_wb_valid=1, rd=5, data=0x1234 -> next cycle RegWrite=1, Rd=5, Write_data=0x1234; pending stays 0.
- Load round trip:
  - ld_issue rd=7 -> pending[7]=1 and hazard=1 with chk_rs1=7.
  - Response 0xDEAD accepted -> RegWrite=1, Rd=7, Write_data=0xDEAD two cycles later (one cycle with WB_LD_BYPASS_EN); pending[7]=0.
- Priority and backpressure:
  - Loads rd=3 and rd=4 pending; ALU valid for 4 cycles while responses 0xA and 0xB arrive.
  - Queue reaches 2 and ld_rsp_ready=0; a third response is held.
  - After ALU stops, writes to 3 then 4 occur in order.
- x0: ALU rd=0 and a load response rd=0 -> RegWrite stays 0; the queue still drains; pending[0]=0.
- Same-cycle set/clear: a pop of rd=9 coincides with ld_issue rd=9 -> pending[9]=1 after the edge.
- Reset mid-operation: queue holding 2 entries, pending=0x18; assert rst=0 off-edge -> immediately lq_count=0, pending=0, RegWrite=0; after release ld_rsp_ready=1.
